// File: rtl/fp_accumulate_driver.sv
// Streams floats through an external IEEE single adder, keeping a running sum
// per stream and emitting the total and element count when the last element lands.
module fp_accumulate_driver #(
    parameter int COUNT_WIDTH = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [31:0]            input_x,
    input  logic                   input_x_last,
    input  logic                   input_x_stb,
    output logic                   input_x_ack,
    output logic [31:0]            adder_a,
    output logic                   adder_a_stb,
    input  logic                   adder_a_ack,
    output logic [31:0]            adder_b,
    output logic                   adder_b_stb,
    input  logic                   adder_b_ack,
    input  logic [31:0]            adder_z,
    input  logic                   adder_z_stb,
    output logic                   adder_z_ack,
    output logic [31:0]            output_sum,
    output logic [COUNT_WIDTH-1:0] output_count,
    output logic                   output_sum_stb,
    input  logic                   output_sum_ack
);

    typedef enum logic [2:0] {GET_X, PUT_A, PUT_B, GET_Z, PUT_SUM} state_t;

    state_t                 state_reg, state_next;
    logic [31:0]            x_reg, x_next;
    logic                   last_reg, last_next;
    logic [31:0]            acc_reg, acc_next;
    logic [COUNT_WIDTH-1:0] count_reg, count_next;
    logic [31:0]            adder_a_reg, adder_a_next;
    logic [31:0]            adder_b_reg, adder_b_next;
    logic [31:0]            output_sum_reg, output_sum_next;
    logic [COUNT_WIDTH-1:0] output_count_reg, output_count_next;
    logic                   input_x_ack_reg, input_x_ack_next;
    logic                   adder_a_stb_reg, adder_a_stb_next;
    logic                   adder_b_stb_reg, adder_b_stb_next;
    logic                   adder_z_ack_reg, adder_z_ack_next;
    logic                   output_sum_stb_reg, output_sum_stb_next;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg          <= GET_X;
            x_reg              <= 32'h0;
            last_reg           <= 1'b0;
            acc_reg            <= 32'h0;
            count_reg          <= '0;
            adder_a_reg        <= 32'h0;
            adder_b_reg        <= 32'h0;
            output_sum_reg     <= 32'h0;
            output_count_reg   <= '0;
            input_x_ack_reg    <= 1'b0;
            adder_a_stb_reg    <= 1'b0;
            adder_b_stb_reg    <= 1'b0;
            adder_z_ack_reg    <= 1'b0;
            output_sum_stb_reg <= 1'b0;
        end else begin
            state_reg          <= state_next;
            x_reg              <= x_next;
            last_reg           <= last_next;
            acc_reg            <= acc_next;
            count_reg          <= count_next;
            adder_a_reg        <= adder_a_next;
            adder_b_reg        <= adder_b_next;
            output_sum_reg     <= output_sum_next;
            output_count_reg   <= output_count_next;
            input_x_ack_reg    <= input_x_ack_next;
            adder_a_stb_reg    <= adder_a_stb_next;
            adder_b_stb_reg    <= adder_b_stb_next;
            adder_z_ack_reg    <= adder_z_ack_next;
            output_sum_stb_reg <= output_sum_stb_next;
        end
    end

    // Each handshake state raises its strobe/ack one cycle after entry and
    // drops it in the same update that performs the transfer.
    always_comb begin
        state_next          = state_reg;
        x_next              = x_reg;
        last_next           = last_reg;
        acc_next            = acc_reg;
        count_next          = count_reg;
        adder_a_next        = adder_a_reg;
        adder_b_next        = adder_b_reg;
        output_sum_next     = output_sum_reg;
        output_count_next   = output_count_reg;
        input_x_ack_next    = input_x_ack_reg;
        adder_a_stb_next    = adder_a_stb_reg;
        adder_b_stb_next    = adder_b_stb_reg;
        adder_z_ack_next    = adder_z_ack_reg;
        output_sum_stb_next = output_sum_stb_reg;
        case (state_reg)
            GET_X: begin
                input_x_ack_next = 1'b1;
                if (input_x_ack_reg && input_x_stb) begin
                    x_next           = input_x;
                    last_next        = input_x_last;
                    input_x_ack_next = 1'b0;
                    if (count_reg != '1) count_next = count_reg + COUNT_WIDTH'(1);
                    state_next       = PUT_A;
                end
            end
            PUT_A: begin
                adder_a_next     = acc_reg;
                adder_a_stb_next = 1'b1;
                if (adder_a_stb_reg && adder_a_ack) begin
                    adder_a_stb_next = 1'b0;
                    state_next       = PUT_B;
                end
            end
            PUT_B: begin
                adder_b_next     = x_reg;
                adder_b_stb_next = 1'b1;
                if (adder_b_stb_reg && adder_b_ack) begin
                    adder_b_stb_next = 1'b0;
                    state_next       = GET_Z;
                end
            end
            GET_Z: begin
                adder_z_ack_next = 1'b1;
                if (adder_z_ack_reg && adder_z_stb) begin
                    acc_next         = adder_z;
                    adder_z_ack_next = 1'b0;
                    state_next       = last_reg ? PUT_SUM : GET_X;
                end
            end
            PUT_SUM: begin
                output_sum_next     = acc_reg;
                output_count_next   = count_reg;
                output_sum_stb_next = 1'b1;
                if (output_sum_stb_reg && output_sum_ack) begin
                    output_sum_stb_next = 1'b0;
                    acc_next            = 32'h0;
                    count_next          = '0;
                    state_next          = GET_X;
                end
            end
            default: state_next = GET_X;
        endcase
    end

    assign input_x_ack    = input_x_ack_reg;
    assign adder_a        = adder_a_reg;
    assign adder_a_stb    = adder_a_stb_reg;
    assign adder_b        = adder_b_reg;
    assign adder_b_stb    = adder_b_stb_reg;
    assign adder_z_ack    = adder_z_ack_reg;
    assign output_sum     = output_sum_reg;
    assign output_count   = output_count_reg;
    assign output_sum_stb = output_sum_stb_reg;

endmodule

// File: tb/tb_fp_accumulate_driver.sv
// Scoreboard bench: a float-adder agent and an output consumer run beside the
// stream producer; expected totals come from integer sums and IEEE constants.
module tb_fp_accumulate_driver;

    localparam int CW = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic [31:0]   input_x;
    logic          input_x_last, input_x_stb, input_x_ack;
    logic [31:0]   adder_a, adder_b, adder_z;
    logic          adder_a_stb, adder_a_ack, adder_b_stb, adder_b_ack;
    logic          adder_z_stb, adder_z_ack;
    logic [31:0]   output_sum;
    logic [CW-1:0] output_count;
    logic          output_sum_stb, output_sum_ack;

    fp_accumulate_driver #(.COUNT_WIDTH(CW)) dut (
        .clk(clk), .rst(rst),
        .input_x(input_x), .input_x_last(input_x_last),
        .input_x_stb(input_x_stb), .input_x_ack(input_x_ack),
        .adder_a(adder_a), .adder_a_stb(adder_a_stb), .adder_a_ack(adder_a_ack),
        .adder_b(adder_b), .adder_b_stb(adder_b_stb), .adder_b_ack(adder_b_ack),
        .adder_z(adder_z), .adder_z_stb(adder_z_stb), .adder_z_ack(adder_z_ack),
        .output_sum(output_sum), .output_count(output_count),
        .output_sum_stb(output_sum_stb), .output_sum_ack(output_sum_ack)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0]   sum;
        logic [CW-1:0] cnt;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   failures = 0;
    int   z_xfers = 0;
    int   a_lo = 0, a_hi = 0, b_lo = 0, b_hi = 0, z_lo = 0, z_hi = 0, o_lo = 0, o_hi = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    function automatic int pick(input int lo, input int hi);
        return int'($urandom_range(hi, lo));
    endfunction

    // IEEE single add, round to nearest even, used by the adder agent.
    function automatic logic [31:0] fp_add(input logic [31:0] a, input logic [31:0] b);
        logic [31:0] l, s;
        logic [63:0] ml, ms, sum, mask;
        logic [24:0] m;
        logic        sign, lost, g, rest;
        int          el, es, d, e;
        if ((a[30:23] == 8'hff && a[22:0] != 0) || (b[30:23] == 8'hff && b[22:0] != 0))
            return 32'h7fc00000;
        if (a[30:23] == 8'hff && b[30:23] == 8'hff)
            return (a[31] == b[31]) ? a : 32'h7fc00000;
        if (a[30:23] == 8'hff) return a;
        if (b[30:23] == 8'hff) return b;
        if (a[30:0] == 0 && b[30:0] == 0) return {a[31] & b[31], 31'h0};
        if (a[30:0] == 0) return b;
        if (b[30:0] == 0) return a;
        if (a[30:0] >= b[30:0]) begin l = a; s = b; end
        else begin l = b; s = a; end
        el = (l[30:23] == 0) ? 1 : int'(l[30:23]);
        es = (s[30:23] == 0) ? 1 : int'(s[30:23]);
        ml = {40'h0, l[30:23] != 0, l[22:0]} << 26;
        ms = {40'h0, s[30:23] != 0, s[22:0]} << 26;
        d  = el - es;
        if (d >= 64) begin
            ms = (ms != 0) ? 64'd1 : 64'd0;
        end else begin
            mask = (64'd1 << d) - 64'd1;
            lost = |(ms & mask);
            ms   = (ms >> d) | {63'h0, lost};
        end
        sign = l[31];
        sum  = (l[31] == s[31]) ? ml + ms : ml - ms;
        if (sum == 0) return 32'h0;
        e = el;
        if (sum[50]) begin
            sum = (sum >> 1) | {63'h0, sum[0]};
            e++;
        end
        while (!sum[49] && e > 1) begin
            sum = sum << 1;
            e--;
        end
        g    = sum[25];
        rest = |sum[24:0];
        m    = {1'b0, sum[49:26]};
        if (g && (rest || m[0])) m = m + 25'd1;
        if (m[24]) begin
            m = m >> 1;
            e++;
        end
        if (e >= 255) return {sign, 8'hff, 23'h0};
        if (!m[23]) return {sign, 8'h0, m[22:0]};
        return {sign, e[7:0], m[22:0]};
    endfunction

    // Exact encoding of small integers, the reference for random streams.
    function automatic logic [31:0] int2float(input int v);
        int          av, p;
        logic [63:0] mant;
        if (v == 0) return 32'h0;
        av = (v < 0) ? -v : v;
        p  = 0;
        for (int i = 0; i < 31; i++) if (av[i]) p = i;
        mant = 64'(av) << (23 - p);
        return {v < 0, 8'(127 + p), mant[22:0]};
    endfunction

    task automatic expect_out(input logic [31:0] sum, input int cnt);
        exp_t e;
        e.sum = sum;
        e.cnt = (cnt > (2**CW - 1)) ? CW'(2**CW - 1) : CW'(cnt);
        sb_q.push_back(e);
    endtask

    task automatic send(input logic [31:0] x, input logic last);
        bit done = 0;
        input_x      = x;
        input_x_last = last;
        input_x_stb  = 1'b1;
        for (int i = 0; i < 2000 && !done; i++) begin
            @(negedge clk);
            if (input_x_ack) done = 1;
        end
        @(posedge clk); #1;
        input_x_stb = 1'b0;
        checks++;
        if (!done) begin
            failures++;
            $display("FAIL input_timeout actual=no_ack required=ack x=%h", x);
        end
    endtask

    task automatic drain(input string name);
        int i = 0;
        while (sb_q.size() != 0 && i < 3000) begin
            @(posedge clk); #1;
            i++;
        end
        checks++;
        if (sb_q.size() != 0) begin
            failures++;
            $display("FAIL %s_drain actual=%0d_pending required=0", name, sb_q.size());
            sb_q.delete();
        end
        repeat (2) begin @(posedge clk); #1; end
        $display("stream %s done checks=%0d failures=%0d", name, checks, failures);
    endtask

    // Adder agent: takes a, then b, returns a+b on z with configurable stalls.
    initial begin
        int          phase = 0;
        int          dly = 0;
        logic        a_x, b_x, z_x, a_seen, b_seen, b_early = 1'b0;
        logic [31:0] av = 32'h0, bv = 32'h0;
        adder_a_ack = 1'b0; adder_b_ack = 1'b0; adder_z_stb = 1'b0; adder_z = 32'h0;
        forever begin
            @(negedge clk);
            if (rst) begin
                phase = 0; dly = pick(a_lo, a_hi); b_early = 1'b0;
                adder_a_ack = 1'b0; adder_b_ack = 1'b0; adder_z_stb = 1'b0;
                continue;
            end
            a_x = adder_a_stb && adder_a_ack;
            b_x = adder_b_stb && adder_b_ack;
            z_x = adder_z_stb && adder_z_ack;
            a_seen = adder_a_stb;
            b_seen = adder_b_stb;
            if (phase == 0 && adder_b_stb) b_early = 1'b1;
            if (a_x) av = adder_a;
            if (b_x) bv = adder_b;
            @(posedge clk); #1;
            if (rst) continue;
            case (phase)
                0: if (a_x) begin
                        adder_a_ack = 1'b0;
                        check("b_stb_before_a", 32'(b_early), 32'h0);
                        b_early = 1'b0;
                        phase = 1;
                        dly = pick(b_lo, b_hi);
                    end else if (a_seen) begin
                        if (dly > 0) dly--; else adder_a_ack = 1'b1;
                    end
                1: if (b_x) begin
                        adder_b_ack = 1'b0;
                        adder_z = fp_add(av, bv);
                        phase = 2;
                        dly = pick(z_lo, z_hi);
                    end else if (b_seen) begin
                        if (dly > 0) dly--; else adder_b_ack = 1'b1;
                    end
                default: if (z_x) begin
                        adder_z_stb = 1'b0;
                        z_xfers++;
                        phase = 0;
                        dly = pick(a_lo, a_hi);
                    end else begin
                        if (dly > 0) dly--; else adder_z_stb = 1'b1;
                    end
            endcase
        end
    end

    // Output monitor: stalls ack, checks stability, pops and compares totals.
    initial begin
        int            dly = 0;
        logic          seen = 1'b0, unstable = 1'b0, xack_hi = 1'b0, xfer;
        logic [31:0]   s0 = 32'h0;
        logic [CW-1:0] c0 = '0;
        exp_t          e;
        output_sum_ack = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                output_sum_ack = 1'b0;
                seen = 1'b0;
                continue;
            end
            xfer = output_sum_stb && output_sum_ack;
            if (output_sum_stb) begin
                if (!seen) begin
                    seen = 1'b1; s0 = output_sum; c0 = output_count;
                    unstable = 1'b0; xack_hi = 1'b0; dly = pick(o_lo, o_hi);
                end else if (output_sum !== s0 || output_count !== c0) begin
                    unstable = 1'b1;
                end
                if (input_x_ack) xack_hi = 1'b1;
            end
            if (xfer) begin
                check("out_stable", 32'(unstable), 32'h0);
                check("x_ack_low_during_out", 32'(xack_hi), 32'h0);
                if (sb_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_output actual=%h required=none", output_sum);
                end else begin
                    e = sb_q.pop_front();
                    check("sum", output_sum, e.sum);
                    check("count", 32'(output_count), 32'(e.cnt));
                end
            end
            @(posedge clk); #1;
            if (xfer) begin
                output_sum_ack = 1'b0;
                seen = 1'b0;
            end else if (seen) begin
                if (dly > 0) dly--; else output_sum_ack = 1'b1;
            end
        end
    end

    initial begin
        bit ok;
        int z0, len, total;
        int v;
        rst = 1'b1;
        input_x = 32'h0; input_x_last = 1'b0; input_x_stb = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_handshakes", 32'({input_x_ack, adder_a_stb, adder_b_stb, adder_z_ack, output_sum_stb}), 32'h0);
        check("rst_adder_a", adder_a, 32'h0);
        check("rst_adder_b", adder_b, 32'h0);
        check("rst_output_sum", output_sum, 32'h0);
        check("rst_output_count", 32'(output_count), 32'h0);
        @(posedge clk); #1;
        rst = 1'b0;

        o_lo = 3; o_hi = 3;
        expect_out(32'h3f800000, 1);
        send(32'h3f800000, 1'b1);
        drain("single");
        o_lo = 0; o_hi = 0;

        z0 = z_xfers;
        expect_out(32'h40c00000, 3);
        send(32'h3f800000, 1'b0);
        send(32'h40000000, 1'b0);
        send(32'h40400000, 1'b1);
        drain("three");
        check("adder_xfer_sets", 32'(z_xfers - z0), 32'd3);

        expect_out(32'h00000000, 2);
        send(32'h3f800000, 1'b0);
        send(32'hbf800000, 1'b1);
        drain("cancel");

        o_lo = 10; o_hi = 10;
        expect_out(32'h3f800000, 1);
        send(32'h3f800000, 1'b1);
        drain("backpressure");
        o_lo = 0; o_hi = 0;
        expect_out(32'h40000000, 1);
        send(32'h40000000, 1'b1);
        drain("after_clear");

        a_lo = 5; a_hi = 5;
        expect_out(32'h40400000, 2);
        send(32'h3f800000, 1'b0);
        send(32'h40000000, 1'b1);
        drain("a_stall");
        a_lo = 0; a_hi = 0;

        expect_out(32'h7f800000, 2);
        send(32'h7f800000, 1'b0);
        send(32'h3f800000, 1'b1);
        drain("inf");

        expect_out(32'h41100000, 9);
        for (int i = 0; i < 9; i++) send(32'h3f800000, i == 8);
        drain("saturate");

        a_hi = 3; b_hi = 3; z_hi = 3; o_hi = 3;
        for (int s = 0; s < 100; s++) begin
            len = pick(1, 7);
            total = 0;
            for (int i = 0; i < len; i++) begin
                v = pick(0, 2000) - 1000;
                total += v;
                if (i == 0) expect_out(int2float(0), 0);
                sb_q[sb_q.size() - 1].sum = int2float(total);
                sb_q[sb_q.size() - 1].cnt = CW'(i + 1);
                send(int2float(v), i == len - 1);
                repeat (pick(0, 2)) begin @(posedge clk); #1; end
            end
        end
        drain("random");
        a_hi = 0; b_hi = 0; o_hi = 0;

        z_lo = 20; z_hi = 20;
        send(32'h3f800000, 1'b1);
        ok = 0;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(negedge clk);
            if (adder_z_ack) ok = 1;
        end
        check("reach_get_z", 32'(ok), 32'h1);
        #2 rst = 1'b1;
        #1;
        check("async_rst_handshakes", 32'({input_x_ack, adder_a_stb, adder_b_stb, adder_z_ack, output_sum_stb}), 32'h0);
        check("async_rst_adder_a", adder_a, 32'h0);
        z_lo = 0; z_hi = 0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        expect_out(32'h3f800000, 1);
        send(32'h3f800000, 1'b1);
        drain("post_reset");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
